// File: rtl/score_if.sv
// score_if: groups the game-event inputs and score/status outputs of the
// score keeper. The slave side is the score keeper. The master side is the
// game logic together with the display stage.
interface score_if;
    logic       start;
    logic       point_evt;
    logic [3:0] point_val;
    logic       opp_evt;
    logic [3:0] opp_val;
    logic [9:0] placar;
    logic [9:0] placarOponente;
    logic [7:0] time_left;
    logic       playing;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        output start, point_evt, point_val, opp_evt, opp_val,
        input  placar, placarOponente, time_left, playing, game_over, winner
    );

    modport slave (
        input  start, point_evt, point_val, opp_evt, opp_val,
        output placar, placarOponente, time_left, playing, game_over, winner
    );
endinterface

// File: rtl/score_keeper.sv
// score_keeper: two-player score accumulator with a round timer and winner
// decision. Scores saturate at 999 so that the three-digit display cannot wrap.
// Every output comes straight from a register.
module score_keeper #(
    parameter int WIN_SCORE     = 100,
    parameter int ROUND_SECS    = 120,
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic    clk,
    input  logic    reset,
    score_if.slave  bus
);

    localparam int              TW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TW-1:0]   TICK_LAST  = TW'(TICKS_PER_SEC - 1);
    localparam logic [TW-1:0]   TICK_ONE   = TW'(1);
    localparam logic [9:0]      SCORE_MAX  = 10'd999;
    localparam logic [9:0]      WIN_THR    = 10'(WIN_SCORE);
    localparam logic [7:0]      ROUND_LOAD = 8'(ROUND_SECS);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAYING   = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [9:0]      r_placar,     w_placar;
    logic [9:0]      r_placar_opp, w_placar_opp;
    logic [7:0]      r_time_left,  w_time_left;
    logic [TW-1:0]   r_tick,       w_tick;
    logic [1:0]      r_winner,     w_winner;
    logic            r_playing,    w_playing;
    logic            r_game_over,  w_game_over;
    logic            w_p_win;
    logic            w_o_win;
    logic            w_time_up;

    // The sum is formed 11 bits wide so that 999 + 15 cannot wrap before the clamp.
    function automatic logic [9:0] sat_add(input logic [9:0] a, input logic [3:0] b);
        logic [10:0] sum;
        sum = {1'b0, a} + {7'd0, b};
        if (sum > {1'b0, SCORE_MAX}) begin
            return SCORE_MAX;
        end else begin
            return sum[9:0];
        end
    endfunction

    // State register. Reset returns the FSM to IDLE immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic, score and timer updates, and the end-of-round decision.
    always_comb begin
        w_state_next = r_state;
        w_placar     = r_placar;
        w_placar_opp = r_placar_opp;
        w_time_left  = r_time_left;
        w_tick       = r_tick;
        w_winner     = r_winner;
        w_p_win      = 1'b0;
        w_o_win      = 1'b0;
        w_time_up    = 1'b0;

        case (r_state)
            ST_IDLE, ST_GAME_OVER: begin
                // Events are ignored here. Only start does anything.
                if (bus.start) begin
                    w_state_next = ST_PLAYING;
                    w_placar     = 10'd0;
                    w_placar_opp = 10'd0;
                    w_time_left  = ROUND_LOAD;
                    w_tick       = '0;
                    w_winner     = 2'b00;
                end else begin
                    w_state_next = r_state;
                end
            end

            ST_PLAYING: begin
                if (bus.start) begin
                    // A restart drops any event that arrives in the same cycle.
                    w_placar     = 10'd0;
                    w_placar_opp = 10'd0;
                    w_time_left  = ROUND_LOAD;
                    w_tick       = '0;
                    w_winner     = 2'b00;
                end else begin
                    if (bus.point_evt) begin
                        w_placar = sat_add(r_placar, bus.point_val);
                    end else begin
                        w_placar = r_placar;
                    end

                    if (bus.opp_evt) begin
                        w_placar_opp = sat_add(r_placar_opp, bus.opp_val);
                    end else begin
                        w_placar_opp = r_placar_opp;
                    end

                    if (r_tick == TICK_LAST) begin
                        w_tick      = '0;
                        w_time_left = r_time_left - 8'd1;
                    end else begin
                        w_tick      = r_tick + TICK_ONE;
                    end

                    // The decision looks at the post-update scores and timer.
                    w_p_win   = (w_placar     >= WIN_THR);
                    w_o_win   = (w_placar_opp >= WIN_THR);
                    w_time_up = (r_tick == TICK_LAST) && (r_time_left == 8'd1);

                    if (w_p_win && w_o_win) begin
                        w_winner     = 2'b11;
                        w_state_next = ST_GAME_OVER;
                    end else if (w_p_win) begin
                        w_winner     = 2'b01;
                        w_state_next = ST_GAME_OVER;
                    end else if (w_o_win) begin
                        w_winner     = 2'b10;
                        w_state_next = ST_GAME_OVER;
                    end else if (w_time_up) begin
                        if (w_placar > w_placar_opp) begin
                            w_winner = 2'b01;
                        end else if (w_placar < w_placar_opp) begin
                            w_winner = 2'b10;
                        end else begin
                            w_winner = 2'b11;
                        end
                        w_state_next = ST_GAME_OVER;
                    end else begin
                        w_state_next = ST_PLAYING;
                    end
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Status flags are registered together with the state, so they change on the same edge.
        w_playing   = (w_state_next == ST_PLAYING);
        w_game_over = (w_state_next == ST_GAME_OVER);
    end

    // Output and datapath registers. Reset discards any round in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_placar     <= 10'd0;
            r_placar_opp <= 10'd0;
            r_time_left  <= ROUND_LOAD;
            r_tick       <= '0;
            r_winner     <= 2'b00;
            r_playing    <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_placar     <= w_placar;
            r_placar_opp <= w_placar_opp;
            r_time_left  <= w_time_left;
            r_tick       <= w_tick;
            r_winner     <= w_winner;
            r_playing    <= w_playing;
            r_game_over  <= w_game_over;
        end
    end

    assign bus.placar         = r_placar;
    assign bus.placarOponente = r_placar_opp;
    assign bus.time_left      = r_time_left;
    assign bus.playing        = r_playing;
    assign bus.game_over      = r_game_over;
    assign bus.winner         = r_winner;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed stimulus. Each step pushes its hand-computed expected
// outputs into a queue. A separate monitor pops an entry and compares it after
// every clock edge or reset assertion.
module tb_score_keeper;

    logic clk;
    logic reset;

    score_if if_a ();
    score_if if_b ();

    // Main instance uses the small test-plan parameters.
    score_keeper #(.WIN_SCORE(20), .ROUND_SECS(3), .TICKS_PER_SEC(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a.slave)
    );

    // The saturation instance has a long round and a threshold of 999.
    score_keeper #(.WIN_SCORE(999), .ROUND_SECS(200), .TICKS_PER_SEC(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b.slave)
    );

    typedef struct {
        int         sel;
        int         id;
        logic [9:0] p;
        logic [9:0] o;
        logic [7:0] t;
        logic       pl;
        logic       go;
        logic [1:0] w;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_id  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: the DUT presents new outputs after each clock edge and on reset assertion.
    initial begin : monitor
        exp_t       e;
        logic [9:0] ap, ao;
        logic [7:0] at;
        logic       apl, ago;
        logic [1:0] aw;
        forever begin
            @(posedge clk or posedge reset);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.sel == 0) begin
                    ap = if_a.placar; ao = if_a.placarOponente; at = if_a.time_left;
                    apl = if_a.playing; ago = if_a.game_over; aw = if_a.winner;
                end else begin
                    ap = if_b.placar; ao = if_b.placarOponente; at = if_b.time_left;
                    apl = if_b.playing; ago = if_b.game_over; aw = if_b.winner;
                end
                checks++;
                if (ap !== e.p || ao !== e.o || at !== e.t || apl !== e.pl || ago !== e.go || aw !== e.w) begin
                    failures++;
                    $display("FAIL step%0d dut%0d: got p=%0d o=%0d t=%0d playing=%0b go=%0b win=%b, expected p=%0d o=%0d t=%0d playing=%0b go=%0b win=%b",
                             e.id, e.sel, ap, ao, at, apl, ago, aw, e.p, e.o, e.t, e.pl, e.go, e.w);
                end
            end
        end
    end

    // Watchdog against a hung run.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic push_exp(input int sel, input logic [9:0] ep, input logic [9:0] eo,
                            input logic [7:0] et, input logic epl, input logic ego,
                            input logic [1:0] ew);
        exp_t e;
        step_id++;
        e.sel = sel; e.id = step_id; e.p = ep; e.o = eo; e.t = et;
        e.pl = epl; e.go = ego; e.w = ew;
        q.push_back(e);
    endtask

    // Drive one cycle of inputs at the falling edge and queue what must follow the next rising edge.
    task automatic step(input int sel, input logic s, input logic pe, input logic [3:0] pv,
                        input logic oe, input logic [3:0] ov,
                        input logic [9:0] ep, input logic [9:0] eo, input logic [7:0] et,
                        input logic epl, input logic ego, input logic [1:0] ew);
        @(negedge clk);
        if (sel == 0) begin
            if_a.start = s; if_a.point_evt = pe; if_a.point_val = pv;
            if_a.opp_evt = oe; if_a.opp_val = ov;
            if_b.start = 1'b0; if_b.point_evt = 1'b0; if_b.point_val = 4'd0;
            if_b.opp_evt = 1'b0; if_b.opp_val = 4'd0;
        end else begin
            if_b.start = s; if_b.point_evt = pe; if_b.point_val = pv;
            if_b.opp_evt = oe; if_b.opp_val = ov;
            if_a.start = 1'b0; if_a.point_evt = 1'b0; if_a.point_val = 4'd0;
            if_a.opp_evt = 1'b0; if_a.opp_val = 4'd0;
        end
        push_exp(sel, ep, eo, et, epl, ego, ew);
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        if_a.start = 1'b0; if_a.point_evt = 1'b0; if_a.point_val = 4'd0;
        if_a.opp_evt = 1'b0; if_a.opp_val = 4'd0;
        if_b.start = 1'b0; if_b.point_evt = 1'b0; if_b.point_val = 4'd0;
        if_b.opp_evt = 1'b0; if_b.opp_val = 4'd0;
    endtask

    initial begin : stimulus
        reset = 1'b1;
        if_a.start = 1'b0; if_a.point_evt = 1'b0; if_a.point_val = 4'd0;
        if_a.opp_evt = 1'b0; if_a.opp_val = 4'd0;
        if_b.start = 1'b0; if_b.point_evt = 1'b0; if_b.point_val = 4'd0;
        if_b.opp_evt = 1'b0; if_b.opp_val = 4'd0;
        repeat (2) @(posedge clk);

        // Reset state is held while reset is asserted, even with start pulsed.
        step(0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0,   10'd0, 10'd0, 8'd3, 1'b0, 1'b0, 2'b00);
        idle_inputs();
        reset = 1'b0;

        // IDLE ignores events.
        step(0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0,  10'd0, 10'd0, 8'd3, 1'b0, 1'b0, 2'b00);
        step(0, 1'b0, 1'b1, 4'd5,  1'b0, 4'd0,  10'd0, 10'd0, 8'd3, 1'b0, 1'b0, 2'b00);
        step(0, 1'b0, 1'b0, 4'd0,  1'b1, 4'd7,  10'd0, 10'd0, 8'd3, 1'b0, 1'b0, 2'b00);
        step(0, 1'b0, 1'b1, 4'd15, 1'b1, 4'd15, 10'd0, 10'd0, 8'd3, 1'b0, 1'b0, 2'b00);

        // Accumulate and win: 9, 18, 23. The game ends on the third event, and later events are ignored.
        step(0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0,   10'd0,  10'd0, 8'd3, 1'b1, 1'b0, 2'b00);
        step(0, 1'b0, 1'b1, 4'd9, 1'b0, 4'd0,   10'd9,  10'd0, 8'd3, 1'b1, 1'b0, 2'b00);
        step(0, 1'b0, 1'b1, 4'd9, 1'b0, 4'd0,   10'd18, 10'd0, 8'd3, 1'b1, 1'b0, 2'b00);
        step(0, 1'b0, 1'b1, 4'd5, 1'b0, 4'd0,   10'd23, 10'd0, 8'd3, 1'b0, 1'b1, 2'b01);
        step(0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd4,   10'd23, 10'd0, 8'd3, 1'b0, 1'b1, 2'b01);
        step(0, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0,   10'd23, 10'd0, 8'd3, 1'b0, 1'b1, 2'b01);

        // Start from GAME_OVER, then both sides score in the same cycle and reach 20/20, giving a draw.
        step(0, 1'b1, 1'b0, 4'd0,  1'b0, 4'd0,  10'd0,  10'd0,  8'd3, 1'b1, 1'b0, 2'b00);
        step(0, 1'b0, 1'b1, 4'd15, 1'b1, 4'd9,  10'd15, 10'd9,  8'd3, 1'b1, 1'b0, 2'b00);
        step(0, 1'b0, 1'b0, 4'd0,  1'b1, 4'd9,  10'd15, 10'd18, 8'd3, 1'b1, 1'b0, 2'b00);
        step(0, 1'b0, 1'b1, 4'd5,  1'b1, 4'd2,  10'd20, 10'd20, 8'd3, 1'b0, 1'b1, 2'b11);

        // Timeout: opponent leads 3 to 1, and the round ends 12 cycles after start.
        step(0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0,   10'd0, 10'd0, 8'd3, 1'b1, 1'b0, 2'b00);
        step(0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd3,   10'd0, 10'd3, 8'd3, 1'b1, 1'b0, 2'b00);
        step(0, 1'b0, 1'b1, 4'd1, 1'b0, 4'd0,   10'd1, 10'd3, 8'd3, 1'b1, 1'b0, 2'b00);
        step(0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0,   10'd1, 10'd3, 8'd3, 1'b1, 1'b0, 2'b00);
        for (int k = 4; k <= 11; k++) begin
            step(0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 10'd1, 10'd3, 8'(3 - k / 4), 1'b1, 1'b0, 2'b00);
        end
        step(0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0,   10'd1, 10'd3, 8'd0, 1'b0, 1'b1, 2'b10);
        step(0, 1'b0, 1'b1, 4'd5, 1'b0, 4'd0,   10'd1, 10'd3, 8'd0, 1'b0, 1'b1, 2'b10);

        // Timeout with equal scores gives a draw.
        step(0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0,   10'd0, 10'd0, 8'd3, 1'b1, 1'b0, 2'b00);
        step(0, 1'b0, 1'b1, 4'd2, 1'b1, 4'd2,   10'd2, 10'd2, 8'd3, 1'b1, 1'b0, 2'b00);
        for (int k = 2; k <= 11; k++) begin
            step(0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 10'd2, 10'd2, 8'(3 - k / 4), 1'b1, 1'b0, 2'b00);
        end
        step(0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0,   10'd2, 10'd2, 8'd0, 1'b0, 1'b1, 2'b11);

        // Restart mid-round drops the coincident events and restarts the tick counter.
        step(0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0,   10'd0, 10'd0, 8'd3, 1'b1, 1'b0, 2'b00);
        step(0, 1'b0, 1'b1, 4'd7, 1'b0, 4'd0,   10'd7, 10'd0, 8'd3, 1'b1, 1'b0, 2'b00);
        step(0, 1'b1, 1'b1, 4'd5, 1'b1, 4'd4,   10'd0, 10'd0, 8'd3, 1'b1, 1'b0, 2'b00);
        step(0, 1'b0, 1'b1, 4'd2, 1'b0, 4'd0,   10'd2, 10'd0, 8'd3, 1'b1, 1'b0, 2'b00);
        step(0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0,   10'd2, 10'd0, 8'd3, 1'b1, 1'b0, 2'b00);
        step(0, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0,   10'd5, 10'd0, 8'd3, 1'b1, 1'b0, 2'b00);
        step(0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0,   10'd5, 10'd0, 8'd2, 1'b1, 1'b0, 2'b00);

        // Asynchronous reset mid-round, checked 1 ns after assertion and well before the next clock edge.
        idle_inputs();
        @(posedge clk);
        #2;
        push_exp(0, 10'd0, 10'd0, 8'd3, 1'b0, 1'b0, 2'b00);
        reset = 1'b1;
        #2;
        @(negedge clk);
        reset = 1'b0;
        step(0, 1'b0, 1'b1, 4'd4, 1'b0, 4'd0,   10'd0, 10'd0, 8'd3, 1'b0, 1'b0, 2'b00);

        // Saturation: 66 x 15 = 990, then +15 clamps to 999 and the player wins.
        step(1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0,   10'd0, 10'd0, 8'd200, 1'b1, 1'b0, 2'b00);
        for (int k = 1; k <= 66; k++) begin
            step(1, 1'b0, 1'b1, 4'd15, 1'b0, 4'd0, 10'(15 * k), 10'd0, 8'(200 - k / 4), 1'b1, 1'b0, 2'b00);
        end
        step(1, 1'b0, 1'b1, 4'd15, 1'b0, 4'd0,  10'd999, 10'd0, 8'd184, 1'b0, 1'b1, 2'b01);
        step(1, 1'b0, 1'b1, 4'd15, 1'b1, 4'd15, 10'd999, 10'd0, 8'd184, 1'b0, 1'b1, 2'b01);
        idle_inputs();

        // Let the monitor drain the queue within a bounded number of cycles.
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expected entries never compared, required 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
# score_keeper

Game-score accumulator for the two-player rat race. Collects point events from the game logic for the player and the opponent. Runs the round timer and decides the winner. Drives the two 10-bit binary scores that the scoreboard display stage converts to BCD on HEX0–HEX5. Scores saturate at 999 so the three-digit-per-side display never overflows.

## Interface
Parameters:
- WIN_SCORE, 100, score at or above which a side wins immediately; legal range 1..999
- ROUND_SECS, 120, round length in seconds; legal range 1..255
- TICKS_PER_SEC, 50000000, clk cycles per second; the bench overrides it with a small value

Ports:
- clk  in  1  system clock; only clock domain
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; starts or restarts a round
- point_evt  in  1  one-cycle pulse; player scores point_val
- point_val  in  4  points awarded to player (0..15)
- opp_evt  in  1  one-cycle pulse; opponent scores opp_val
- opp_val  in  4  points awarded to opponent (0..15)
- placar  out  10  player score, registered, binary 0..999
- placarOponente  out  10  opponent score, registered, binary 0..999
- time_left  out  8  seconds remaining, registered
- playing  out  1  high in PLAYING
- game_over  out  1  high in GAME_OVER
- winner  out  2  00 none, 01 player, 10 opponent, 11 draw

Clock and reset are fixed as stated: one clock, `clk`; reset is asynchronous and active-high, `reset`.

## Operation
- FSM states: IDLE, PLAYING, GAME_OVER. All outputs are registered.
- Reset behaviour (asynchronous):
  - State goes to IDLE.
  - placar = 0, placarOponente = 0, time_left = ROUND_SECS.
  - Tick counter = 0, playing = 0, game_over = 0, winner = 00.
  - Reset mid-round discards everything.
- IDLE:
  - Events are ignored.
  - start moves to PLAYING and clears scores, tick counter and winner.
  - time_left reloads to ROUND_SECS.
- PLAYING, each cycle:
  - If start is high: restart. Clear scores, tick counter and winner; reload the timer; stay in PLAYING. Events arriving in the same cycle are dropped.
  - Otherwise, if point_evt is high: placar_next = min(placar + point_val, 999). The sum is computed 11 bits wide before the clamp.
  - opp_evt is handled the same way for placarOponente. Both events are applied in the same cycle when they coincide.
  - Tick counter counts 0..TICKS_PER_SEC-1 and wraps. On wrap, time_left decrements by 1.
  - The end decision uses the updated (next) scores:
    - Both next scores ≥ WIN_SCORE: winner = 11.
    - Only the player's ≥ WIN_SCORE: winner = 01.
    - Only the opponent's ≥ WIN_SCORE: winner = 10.
    - Otherwise, if time_left becomes 0 this cycle: the higher score wins; equal scores give 11.
    - When any of these fires, go to GAME_OVER.
- GAME_OVER:
  - Scores, time_left and winner are frozen; events are ignored.
  - start restarts exactly as from IDLE.
- time_left never underflows. It only decrements in PLAYING, and reaching 0 always exits PLAYING.
- An event with value 0 is accepted and changes nothing.

## Timing
- Event sampled at edge N: the score change is visible on placar/placarOponente after edge N, one cycle of latency.
- game_over, winner and the final score update appear on the same edge. playing drops on that edge.
- start at edge N: playing = 1, scores = 0 and time_left = ROUND_SECS after edge N.
- The first time_left decrement occurs TICKS_PER_SEC cycles after start.
- A round that times out lasts exactly ROUND_SECS × TICKS_PER_SEC cycles from the start edge to the game_over edge.
- No input handshake: every event pulse in PLAYING (without start) is consumed in its cycle. Pulses held high for k cycles count k times.

## Test plan
Bench parameters: TICKS_PER_SEC = 4, ROUND_SECS = 3, WIN_SCORE = 20.

- **Reset state:** reset pulse, no start → placar = 0, placarOponente = 0, time_left = 3, winner = 00, playing = 0. Events in IDLE leave scores at 0.
- **Accumulate and win:** start, then player events 9, 9, 5 → placar 9, 18, 23. GAME_OVER on the third edge with winner = 01. A later opp_evt is ignored.
- **Simultaneous events:** placar = 15 and placarOponente = 18; point_evt 5 and opp_evt 2 in the same cycle → 20 and 20, winner = 11.
- **Timeout:** start, opponent 3, player 1, no further events → time_left steps 3→2→1→0 every 4 cycles. game_over lands 12 cycles after start with winner = 10. An equal-score timeout gives 11.
- **Saturation:** WIN_SCORE = 999, placar = 990, point_val 15 → placar = 999. Further events hold 999 and winner stays 01.
- **Restart and reset mid-round:**
  - start pulse in PLAYING with a simultaneous point_evt → scores 0, time_left 3, event dropped.
  - start in GAME_OVER → PLAYING with cleared scores.
  - reset asserted mid-round → immediate return to reset values, asynchronous, without waiting for clk.
